// File: rtl/pwr_up_seq.sv
// ---------------------------------------------------------------------------
// pwr_up_seq -- power-up sequencer: SETTLE -> SENSE -> CAL -> RUN, with a
// sticky ERR state on sensor loss or timeout.
//
// Optional feature macro: PWR_SEQ_SOFT_RST_EN
//   defined   : soft_rst restarts the sequence from SETTLE (clears seq_err)
//   undefined : soft_rst is ignored and generates no logic
//
// Every output is a flop loaded from the next-state decode, so an output
// change is visible right after the edge that takes the transition, and no
// input reaches an output combinationally.
// ---------------------------------------------------------------------------
module pwr_up_seq #(
  parameter int unsigned SETTLE_CYC = 16,   // 1..65535
  parameter int unsigned TMO_CYC    = 1000  // 2..65535
) (
  input  logic clk,
  input  logic RST_n,
  input  logic sens_rdy,
  input  logic cal_done,
  input  logic soft_rst,
  output logic en_sense,
  output logic strt_cal,
  output logic en_mtr,
  output logic sys_rdy,
  output logic seq_err
);

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_SENSE  = 3'd1,
    ST_CAL    = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  typedef struct packed {
    logic en_sense;
    logic strt_cal;
    logic en_mtr;
    logic sys_rdy;
    logic seq_err;
  } outs_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TMO_CYC - 1);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  // Low for exactly the first edge after reset release; that edge only
  // arms the sequencer, so SETTLE spans SETTLE_CYC counted edges after it.
  logic        rel_q;
  outs_t       outs_q, outs_d;
  logic        soft_hit;

`ifdef PWR_SEQ_SOFT_RST_EN
  assign soft_hit = soft_rst;
`else
  logic unused_soft_rst;
  assign soft_hit        = 1'b0;
  assign unused_soft_rst = soft_rst;
`endif

  // State, counter, release marker and output flops.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
      outs_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge; blocking would chain updates within one edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= 1'b1;
      outs_q  <= outs_d;
    end
  end

  // Next-state decode; soft restart overrides every other transition.
  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      ST_SETTLE: if (rel_q && (cnt_q == SETTLE_LAST)) state_d = ST_SENSE;
      ST_SENSE: begin
        if (sens_rdy)                  state_d = ST_CAL;
        else if (cnt_q == TMO_LAST)    state_d = ST_ERR;
      end
      ST_CAL: begin
        if (!sens_rdy)                 state_d = ST_ERR;
        else if (cal_done)             state_d = ST_RUN;
        else if (cnt_q == TMO_LAST)    state_d = ST_ERR;
      end
      ST_RUN:    if (!sens_rdy) state_d = ST_ERR;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_SETTLE;
    endcase
    if (soft_hit) state_d = ST_SETTLE;
  end

  // Cycle counter: cleared on any state change, held at 0 in RUN,
  // frozen during the arming edge, otherwise counts up and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (soft_hit || (state_d != state_q) || (state_q == ST_RUN)) begin
      cnt_d = '0;
    end else if ((state_q == ST_SETTLE) && !rel_q) begin
      cnt_d = cnt_q;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Output decode from the next state; strt_cal only on SENSE->CAL entry.
  always_comb begin
    outs_d = '0;
    unique case (state_d)
      ST_SENSE: outs_d.en_sense = 1'b1;
      ST_CAL: begin
        outs_d.en_sense = 1'b1;
        outs_d.strt_cal = (state_q == ST_SENSE);
      end
      ST_RUN: begin
        outs_d.en_sense = 1'b1;
        outs_d.en_mtr   = 1'b1;
        outs_d.sys_rdy  = 1'b1;
      end
      ST_ERR:    outs_d.seq_err = 1'b1;
      default:   outs_d = '0;
    endcase
  end

  assign en_sense = outs_q.en_sense;
  assign strt_cal = outs_q.strt_cal;
  assign en_mtr   = outs_q.en_mtr;
  assign sys_rdy  = outs_q.sys_rdy;
  assign seq_err  = outs_q.seq_err;

endmodule

// File: tb/tb_pwr_up_seq.sv
// ---------------------------------------------------------------------------
// tb_pwr_up_seq -- self-checking bench for pwr_up_seq (default parameters).
// Output vectors are written {seq_err, sys_rdy, en_mtr, strt_cal, en_sense}.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_pwr_up_seq;

  localparam int SC = 16;
  localparam int TC = 1000;
  localparam int E  = SC + 1;   // edge (after release) where SENSE is entered

  localparam logic [4:0] V_OFF   = 5'b00000;
  localparam logic [4:0] V_SENSE = 5'b00001;
  localparam logic [4:0] V_CAL1  = 5'b00011;
  localparam logic [4:0] V_RUN   = 5'b01101;
  localparam logic [4:0] V_ERR   = 5'b10000;

  logic clk, RST_n, sens_rdy, cal_done, soft_rst;
  logic en_sense, strt_cal, en_mtr, sys_rdy, seq_err;

  int checks   = 0;
  int failures = 0;

  pwr_up_seq #(.SETTLE_CYC(SC), .TMO_CYC(TC)) dut (
    .clk      (clk),
    .RST_n    (RST_n),
    .sens_rdy (sens_rdy),
    .cal_done (cal_done),
    .soft_rst (soft_rst),
    .en_sense (en_sense),
    .strt_cal (strt_cal),
    .en_mtr   (en_mtr),
    .sys_rdy  (sys_rdy),
    .seq_err  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] obs();
    return {seq_err, sys_rdy, en_mtr, strt_cal, en_sense};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    sens_rdy = 1'b0;
    cal_done = 1'b0;
    soft_rst = 1'b0;
    RST_n    = 1'b0;
    repeat (3) tick();
    RST_n = 1'b1;
  endtask

  // Edges until en_sense first reads 1 (-1 if not within bound); also
  // reports whether any other output was high before that.
  task automatic measure_rise(output int edges, output bit other_hi);
    edges    = -1;
    other_hi = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (en_sense === 1'b1) begin
        edges = n;
        break;
      end
      if (obs() !== V_OFF) other_hi = 1'b1;
    end
  endtask

  // Fresh reset, sens_rdy high; returns once the strt_cal pulse is seen.
  task automatic goto_cal(input string tag);
    bit ok = 1'b0;
    apply_reset();
    sens_rdy = 1'b1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (strt_cal === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_reach_cal: strt_cal not seen within 100 edges", tag);
    end
  endtask

  task automatic test_reset();
    int  e;
    bit  hi;
    RST_n = 1'b0; sens_rdy = 1'b1; cal_done = 1'b1; soft_rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (obs() !== V_OFF) begin
      failures++;
      $display("FAIL reset_outputs: got %b required %b", obs(), V_OFF);
    end
    apply_reset();
    measure_rise(e, hi);
    checks++;
    if (e !== E) begin
      failures++;
      $display("FAIL reset_release_timing: en_sense rose at edge %0d required %0d", e, E);
    end
    checks++;
    if (hi) begin
      failures++;
      $display("FAIL reset_settle_quiet: got other outputs high required none");
    end
  endtask

  task automatic test_nominal();
    int first_sense = -1, first_strt = -1, strt_cnt = 0, first_rdy = -1;
    bit any_err = 1'b0;
    apply_reset();
    for (int n = 1; n <= 40; n++) begin
      sens_rdy = (n >= 20);
      cal_done = (n == 30);
      tick();
      if (en_sense === 1'b1 && first_sense < 0) first_sense = n;
      if (strt_cal === 1'b1) begin
        strt_cnt++;
        if (first_strt < 0) first_strt = n;
      end
      if (sys_rdy === 1'b1 && en_mtr === 1'b1 && first_rdy < 0) first_rdy = n;
      if (seq_err !== 1'b0) any_err = 1'b1;
    end
    cal_done = 1'b0;
    checks++;
    if (first_sense !== E) begin
      failures++;
      $display("FAIL nominal_sense_edge: got %0d required %0d", first_sense, E);
    end
    checks++;
    if (first_strt !== 20 || strt_cnt !== 1) begin
      failures++;
      $display("FAIL nominal_strt_cal: first %0d count %0d required first 20 count 1",
               first_strt, strt_cnt);
    end
    checks++;
    if (first_rdy !== 30) begin
      failures++;
      $display("FAIL nominal_run_edge: got %0d required 30", first_rdy);
    end
    checks++;
    if (any_err || obs() !== V_RUN) begin
      failures++;
      $display("FAIL nominal_final: got %b err_seen %0d required %b", obs(), any_err, V_RUN);
    end
  endtask

  task automatic test_sense_timeout();
    int e;
    bit hi, stuck_ok = 1'b1;
    apply_reset();
    measure_rise(e, hi);   // now just after the SENSE entry edge
    repeat (TC - 1) tick();
    checks++;
    if (obs() !== V_SENSE) begin
      failures++;
      $display("FAIL sense_tmo_before: got %b required %b", obs(), V_SENSE);
    end
    tick();
    checks++;
    if (obs() !== V_ERR) begin
      failures++;
      $display("FAIL sense_tmo_at: got %b required %b", obs(), V_ERR);
    end
    for (int i = 0; i < 500; i++) begin
      sens_rdy = 1'($urandom_range(0, 1));
      cal_done = 1'($urandom_range(0, 1));
      tick();
      if (obs() !== V_ERR) stuck_ok = 1'b0;
    end
    sens_rdy = 1'b0; cal_done = 1'b0;
    checks++;
    if (!stuck_ok) begin
      failures++;
      $display("FAIL sense_tmo_sticky: got ERR left within 500 cycles required stay");
    end
  endtask

  task automatic test_cal_boundary();
    int          ks[2]  = '{TC - 1, TC};
    logic [4:0]  req[2] = '{V_RUN, V_ERR};
    for (int i = 0; i < 2; i++) begin
      goto_cal("cal_boundary");
      repeat (ks[i]) tick();
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
      checks++;
      if (obs() !== req[i]) begin
        failures++;
        $display("FAIL cal_boundary_cnt%0d: got %b required %b", ks[i], obs(), req[i]);
      end
    end
  endtask

  task automatic test_run_loss();
    bit run_ok = 1'b1;
    goto_cal("run_loss");
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    repeat ($urandom_range(1, 20)) begin
      tick();
      if (obs() !== V_RUN) run_ok = 1'b0;
    end
    checks++;
    if (!run_ok) begin
      failures++;
      $display("FAIL run_hold: got left RUN with sens_rdy high required stay");
    end
    sens_rdy = 1'b0;
    tick();
    checks++;
    if (obs() !== V_ERR) begin
      failures++;
      $display("FAIL run_loss: got %b required %b", obs(), V_ERR);
    end
  endtask

  task automatic test_cal_drop_and_done();
    goto_cal("cal_drop");
    repeat ($urandom_range(0, 10)) tick();
    sens_rdy = 1'b0;
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    checks++;
    if (obs() !== V_ERR) begin
      failures++;
      $display("FAIL cal_drop_priority: got %b required %b", obs(), V_ERR);
    end
  endtask

  task automatic test_mid_reset(input bit in_run);
    int e;
    bit hi, held_ok = 1'b1;
    goto_cal(in_run ? "midrst_run" : "midrst_cal");
    if (in_run) begin
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
      tick();
    end
    RST_n = 1'b0;
    #2;
    checks++;
    if (obs() !== V_OFF) begin
      failures++;
      $display("FAIL midrst_async_%0d: got %b required %b", in_run, obs(), V_OFF);
    end
    repeat (3) begin
      tick();
      if (obs() !== V_OFF) held_ok = 1'b0;
    end
    RST_n = 1'b1;
    measure_rise(e, hi);
    checks++;
    if (!held_ok || hi || e !== E) begin
      failures++;
      $display("FAIL midrst_restart_%0d: rise edge %0d held_ok %0d other_hi %0d required %0d 1 0",
               in_run, e, held_ok, hi, E);
    end
  endtask

  task automatic test_soft_rst();
    goto_cal("soft");
    sens_rdy = 1'b0;
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
`ifdef PWR_SEQ_SOFT_RST_EN
    begin
      int e;
      bit hi;
      checks++;
      if (obs() !== V_OFF) begin
        failures++;
        $display("FAIL soft_rst_clear: got %b required %b", obs(), V_OFF);
      end
      measure_rise(e, hi);
      checks++;
      if (e !== SC || hi) begin
        failures++;
        $display("FAIL soft_rst_restart: rise edge %0d other_hi %0d required %0d 0", e, hi, SC);
      end
    end
`else
    checks++;
    if (obs() !== V_ERR) begin
      failures++;
      $display("FAIL soft_rst_ignored: got %b required %b", obs(), V_ERR);
    end
    repeat (20) tick();
    checks++;
    if (obs() !== V_ERR) begin
      failures++;
      $display("FAIL soft_rst_ignored_later: got %b required %b", obs(), V_ERR);
    end
`endif
  endtask

  // Timeline reference: r = SENSE cycles before sens_rdy is seen, d = CAL
  // cycles before cal_done is seen, h = extra RUN cycles before sens_rdy drops.
  function automatic logic [4:0] exp_at(int n, int r, int d, int h);
    int c, rr;
    if (n <= SC) return V_OFF;
    if (r > TC - 1) return (n < E + TC) ? V_SENSE : V_ERR;
    c = E + r + 1;
    if (n < c)  return V_SENSE;
    if (n == c) return V_CAL1;
    if (d > TC - 1) return (n < c + TC) ? V_SENSE : V_ERR;
    rr = c + d + 1;
    if (n < rr)      return V_SENSE;
    if (n <= rr + h) return V_RUN;
    return V_ERR;
  endfunction

  function automatic int pick_delay();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, 30);
      1:       return $urandom_range(TC - 4, TC + 3);
      default: return $urandom_range(31, 200);
    endcase
  endfunction

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      int r = pick_delay();
      int d = pick_delay();
      int h = $urandom_range(0, 30);
      int c = E + r + 1;
      int rr = c + d + 1;
      int drop_n, end_n, bad = 0;
      if (r > TC - 1)      begin end_n = E + TC + 20;  drop_n = 1 << 30; end
      else if (d > TC - 1) begin end_n = c + TC + 20;  drop_n = 1 << 30; end
      else                 begin end_n = rr + h + 21;  drop_n = rr + h;  end
      apply_reset();
      for (int n = 0; n < end_n; n++) begin
        sens_rdy = (n >= E + r) && (n < drop_n);
        cal_done = (r <= TC - 1) && (n == c + d);
        tick();
        if (obs() !== exp_at(n + 1, r, d, h)) begin
          if (bad == 0)
            $display("FAIL random_%0d edge %0d: got %b required %b (r=%0d d=%0d h=%0d)",
                     s, n + 1, obs(), exp_at(n + 1, r, d, h), r, d, h);
          bad++;
        end
      end
      cal_done = 1'b0;
      checks++;
      if (bad != 0) failures++;
    end
  endtask

  initial begin
    RST_n = 1'b0; sens_rdy = 1'b0; cal_done = 1'b0; soft_rst = 1'b0;
    test_reset();
    test_nominal();
    test_sense_timeout();
    test_cal_boundary();
    test_run_loss();
    test_cal_drop_and_done();
    test_mid_reset(1'b0);
    test_mid_reset(1'b1);
    test_soft_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
